ifetch_unit: RTL and testbench

- Instruction-fetch initiator for the single-issue core.
- Drives the word address into the combinational instruction ROM and samples the returned word in the same cycle.
- Buffers {pc, instr} pairs in a small FIFO and hands them to decode with a valid/ready handshake.
- Accepts PC redirects from execute (branch/jump); a redirect flushes all wrong-path entries.

---
 rtl/core_pkg.sv | 14 +
 rtl/ifetch_unit_if.sv | 32 +++
 rtl/ifetch_unit_fifo.sv | 64 ++++++
 rtl/ifetch_unit.sv | 100 ++++++++++
 tb/tb_ifetch_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types: architectural widths, reset vector and the fetch-buffer entry.
package core_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch bus: combinational ROM port plus the valid/ready hand-off to decode.
interface ifetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0]    instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_instr;
  logic [ADDRESS_WIDTH-1:0] out_pc;

  modport master (
    output instr_addr,
    input  instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  instr_addr,
    output instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/ifetch_unit_fifo.sv
// fetch_fifo: small power-of-two FIFO of {pc, instr}; synchronous flush beats push/pop.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, ROM access, fetch buffer and decode hand-off.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module ifetch_unit
  import core_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = XLEN,
  parameter int                       DATA_WIDTH    = ILEN,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_VECTOR),
  parameter int                       DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ifetch_unit_if.master            bus,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall,
  output logic [31:0]              perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]            count;
  logic                     full;
  logic                     pop;
  logic                     fetch;
  fetch_entry_t             push_entry;
  fetch_entry_t             head;

  assign full          = (count == CW'(DEPTH));
  // Gate valid during a redirect so a wrong-path head can never transfer.
  assign bus.out_valid = (count != '0) & ~redirect_valid;
  assign pop           = bus.out_valid & bus.out_ready;
  assign fetch         = ~redirect_valid & (~full | pop);

  assign bus.instr_addr   = pc_q;
  assign push_entry.pc    = XLEN'(pc_q);
  assign push_entry.instr = ILEN'(bus.instr);
  assign bus.out_pc       = ADDRESS_WIDTH'(head.pc);
  assign bus.out_instr    = DATA_WIDTH'(head.instr);

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
    else if (fetch)
      pc_d = pc_q + ADDRESS_WIDTH'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

`ifdef IFETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q,   stall_d;
  logic [31:0] flushed_q, flushed_d;

  always_comb begin
    fetched_d = fetched_q + 32'(fetch);
    stall_d   = stall_q + 32'(full & ~pop & ~redirect_valid);
    flushed_d = redirect_valid ? flushed_q + 32'(count) : flushed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
      flushed_q <= flushed_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: two instances (reset PC 0 and near-wrap), ROM word[k] = k.
module tb_ifetch_unit;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_valid1;
  logic [31:0] redirect_pc1;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  ifetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ifetch_unit_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  assign bus0.instr = bus0.instr_addr >> 2;
  assign bus1.instr = bus1.instr_addr >> 2;
  assign bus1.out_ready = 1'b1;

`ifdef IFETCH_PERF_EN
  logic [31:0] pf0, ps0, pl0, pf1, ps1, pl1;
`endif

  ifetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0000_0000),
    .DEPTH         (2)
  ) dut0 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus0.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (pf0),
    .perf_stall     (ps0),
    .perf_flushed   (pl0)
`endif
  );

  ifetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'hFFFF_FFF8),
    .DEPTH         (2)
  ) dut1 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus1.master),
    .redirect_valid (redirect_valid1),
    .redirect_pc    (redirect_pc1)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (pf1),
    .perf_stall     (ps1),
    .perf_flushed   (pl1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    redirect_valid1 = 1'b0;
    redirect_pc1    = '0;
    bus0.out_ready  = 1'b0;
    step();
    step();

    // Reset state
    check_eq("rst_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_addr",  bus0.instr_addr,     32'h0);
    check_eq("rst_pc",    bus0.out_pc,         32'h0);
    check_eq("rst_instr", bus0.out_instr,      32'h0);
    check_eq("rst_addr1", bus1.instr_addr,     32'hFFFF_FFF8);

    // Streaming with out_ready=1; dut1 shows the PC wrap
    rst            = 1'b0;
    bus0.out_ready = 1'b1;
    exp_pc         = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("strm_valid", 32'(bus0.out_valid), 32'd1);
      check_eq("strm_pc",    bus0.out_pc,         32'(4 * k));
      check_eq("strm_instr", bus0.out_instr,      32'(k));
      if (k < 3) begin
        check_eq("wrap_pc",    bus1.out_pc,    exp_pc);
        check_eq("wrap_instr", bus1.out_instr, exp_pc >> 2);
        exp_pc = exp_pc + 32'd4;
      end
    end

    // Back-pressure: fill, hold, then drain without bubbles
    rst            = 1'b1;
    bus0.out_ready = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    check_eq("hold_count", 32'(dut0.count),     32'd2);
    check_eq("hold_addr",  bus0.instr_addr,     32'h8);
    check_eq("hold_valid", 32'(bus0.out_valid), 32'd1);
    check_eq("hold_head",  bus0.out_pc,         32'h0);
`ifdef IFETCH_PERF_EN
    check_eq("perf_fetched", pf0, 32'd2);
    check_eq("perf_stall",   ps0, 32'd8);
`endif
    bus0.out_ready = 1'b1;
    #1;
    check_eq("drain0", bus0.out_pc, 32'h0);
    step();
    check_eq("drain1",       bus0.out_pc,         32'h4);
    check_eq("drain1_valid", 32'(bus0.out_valid), 32'd1);
    step();
    check_eq("drain2",       bus0.out_pc,         32'h8);
    check_eq("drain2_valid", 32'(bus0.out_valid), 32'd1);

    // Redirect while full (FIFO holds 8 and 12)
    check_eq("pre_redir_cnt", 32'(dut0.count), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    check_eq("redir_gate", 32'(bus0.out_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("redir_pc",    bus0.instr_addr,     32'h100);
    check_eq("redir_empty", 32'(bus0.out_valid), 32'd0);
    step();
    check_eq("redir_valid", 32'(bus0.out_valid), 32'd1);
    check_eq("redir_head",  bus0.out_pc,         32'h100);
    check_eq("redir_instr", bus0.out_instr,      32'h40);
`ifdef IFETCH_PERF_EN
    check_eq("perf_flushed", pl0, 32'd2);
`endif

    // Back-to-back redirects: last one wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_pc = 32'h80;
    #1;
    check_eq("b2b_gate",  32'(bus0.out_valid), 32'd0);
    check_eq("b2b_first", bus0.instr_addr,     32'h40);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("b2b_pc", bus0.instr_addr, 32'h80);
    step();
    check_eq("b2b_valid", 32'(bus0.out_valid), 32'd1);
    check_eq("b2b_head",  bus0.out_pc,         32'h80);

    // Reset together with redirect mid-stream
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("mrst_count", 32'(dut0.count),     32'd0);
    check_eq("mrst_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("mrst_pc",    bus0.instr_addr,     32'h0);
    check_eq("mrst_head",  bus0.out_pc,         32'h0);
`ifdef IFETCH_PERF_EN
    check_eq("mrst_fetched", pf0, 32'd0);
    check_eq("mrst_stall",   ps0, 32'd0);
    check_eq("mrst_flushed", pl0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
